// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite types and constants for the animation controllers
//
// Purpose: holds the animation state enum and the per-frame ROM size of the
// Ryu sprite sheet. The renderers use FRAME_WORDS_RYU for the per-pixel
// offset as well, so both sides of the ROM address agree on the frame size.
// Ports: none (package).
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PUNCH    = 2'd1,
        COOLDOWN = 2'd2
    } anim_state_t;

    // One Ryu frame is 92 x 90 pixels, one ROM word per pixel.
    localparam int unsigned FRAME_WORDS_RYU = 92 * 90;

endpackage

// File: rtl/rise_edge_det.sv
// rtl/rise_edge_det.sv - single-flop rising-edge detector for synchronised button levels
//
// Purpose: flags the cycle in which a level input goes from 0 to 1.
// Ports:
//   clk_i   in  1  clock
//   rst_ni  in  1  asynchronous active-low reset
//   d_i     in  1  level input (already synchronised to clk_i)
//   rise_o  out 1  high for the one cycle where d_i is 1 and was 0 last cycle
module rise_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/ryu_anim_sequencer.sv
// rtl/ryu_anim_sequencer.sv - frame-synchronous punch animation sequencer for the Ryu sprite
//
// Purpose: turns a punch request into a timed sequence of sprite frames and
// outputs the ROM base address of the frame on show. Every visible change
// happens on the vertical-blank tick so a frame never switches mid-scan.
// Ports:
//   vga_clk     in  1       pixel clock
//   reset_n     in  1       asynchronous active-low reset
//   frame_tick  in  1       one-cycle pulse at start of vertical blank
//   punch_req   in  1       synchronised button level; rising edge requests a punch
//   frame_base  out ADDR_W  ROM word address of the current frame's first pixel
//   frame_idx   out IDX_W   current frame number, 0 = stance
//   busy        out 1       high during PUNCH and COOLDOWN
//   anim_done   out 1       one-cycle pulse when COOLDOWN ends
module ryu_anim_sequencer
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_FRAMES     = 3,
    parameter int unsigned HOLD_TICKS     = 4,
    parameter int unsigned COOLDOWN_TICKS = 8,
    parameter int unsigned FRAME_WORDS    = FRAME_WORDS_RYU,
    parameter int unsigned ADDR_W         = 16
) (
    input  logic                              vga_clk,
    input  logic                              reset_n,
    input  logic                              frame_tick,
    input  logic                              punch_req,
    output logic [ADDR_W-1:0]                 frame_base,
    output logic [$clog2(NUM_FRAMES+1)-1:0]   frame_idx,
    output logic                              busy,
    output logic                              anim_done
);

    localparam int unsigned IDX_W   = $clog2(NUM_FRAMES + 1);
    localparam int unsigned CNT_MAX = (HOLD_TICKS > COOLDOWN_TICKS) ? HOLD_TICKS : COOLDOWN_TICKS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // The whole sprite sheet, stance frame included, must fit the address bus.
    if (64'(NUM_FRAMES + 1) * 64'(FRAME_WORDS) > (64'd1 << ADDR_W)) begin : g_addr_chk
        $error("ryu_anim_sequencer: (NUM_FRAMES+1)*FRAME_WORDS does not fit in ADDR_W bits");
    end
    if (HOLD_TICKS < 1 || COOLDOWN_TICKS < 1 || NUM_FRAMES < 1) begin : g_param_chk
        $error("ryu_anim_sequencer: NUM_FRAMES, HOLD_TICKS and COOLDOWN_TICKS must be at least 1");
    end

    anim_state_t        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic punch_rise;
    logic want;
    logic take_req;

    rise_edge_det u_punch_edge (
        .clk_i  (vga_clk),
        .rst_ni (reset_n),
        .d_i    (punch_req),
        .rise_o (punch_rise)
    );

    // An edge arriving in the tick cycle itself still counts as a request.
    assign want = pend_q | punch_rise;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        base_d   = base_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        done_d   = 1'b0;
        take_req = 1'b0;

        // Requests made while punching are dropped, not queued.
        if (punch_rise && state_q != PUNCH) begin
            pend_d = 1'b1;
        end

        if (frame_tick) begin
            case (state_q)
                IDLE: begin
                    take_req = want;
                end
                PUNCH: begin
                    // cnt_q is the number of ticks the current frame has been
                    // on screen, counting the tick that put it there.
                    if (cnt_q == CNT_W'(HOLD_TICKS)) begin
                        cnt_d = CNT_W'(1);
                        if (idx_q == IDX_W'(NUM_FRAMES)) begin
                            state_d = COOLDOWN;
                            idx_d   = '0;
                            base_d  = '0;
                        end else begin
                            idx_d  = idx_q + IDX_W'(1);
                            base_d = base_q + ADDR_W'(FRAME_WORDS);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                COOLDOWN: begin
                    // The entry tick is the first cooldown tick, so the exit
                    // tick is the COOLDOWN_TICKS-th one overall.
                    if (cnt_q >= CNT_W'(COOLDOWN_TICKS - 1)) begin
                        done_d = 1'b1;
                        if (want) begin
                            take_req = 1'b1;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    base_d  = '0;
                    cnt_d   = '0;
                end
            endcase

            if (take_req) begin
                state_d = PUNCH;
                idx_d   = IDX_W'(1);
                base_d  = ADDR_W'(FRAME_WORDS);
                cnt_d   = CNT_W'(1);
                pend_d  = 1'b0;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign frame_base = base_q;
    assign frame_idx  = idx_q;
    assign busy       = busy_q;
    assign anim_done  = done_q;

endmodule

// File: tb/tb_ryu_anim_sequencer.sv
// tb/tb_ryu_anim_sequencer.sv - self-checking bench for ryu_anim_sequencer
module tb_ryu_anim_sequencer;

    logic        vga_clk    = 1'b0;
    logic        reset_n    = 1'b0;
    logic        frame_tick = 1'b0;
    logic        punch_req  = 1'b0;
    logic [15:0] frame_base;
    logic [1:0]  frame_idx;
    logic        busy;
    logic        anim_done;

    always #5 vga_clk = ~vga_clk;

    ryu_anim_sequencer #(
        .NUM_FRAMES     (3),
        .HOLD_TICKS     (2),
        .COOLDOWN_TICKS (3),
        .FRAME_WORDS    (8280),
        .ADDR_W         (16)
    ) dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .punch_req  (punch_req),
        .frame_base (frame_base),
        .frame_idx  (frame_idx),
        .busy       (busy),
        .anim_done  (anim_done)
    );

    typedef struct {
        logic        tick;
        logic        punch;
        logic [15:0] base;
        logic [1:0]  idx;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Expected outputs after the k-th tick of a punch (k = 1..9).
    int seq_base [9] = '{8280, 8280, 16560, 16560, 24840, 24840, 0, 0, 0};
    int seq_idx  [9] = '{1, 1, 2, 2, 3, 3, 0, 0, 0};
    int seq_busy [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic t, input logic p, input int b, input int i,
                       input logic bz, input logic d);
        vec_t v;
        v.tick  = t;
        v.punch = p;
        v.base  = 16'(b);
        v.idx   = 2'(i);
        v.busy  = bz;
        v.done  = d;
        vecs.push_back(v);
    endtask

    // Tick row for punch tick k followed by a quiet row where outputs hold.
    task automatic add_tick(input int k, input logic p_tick, input logic p_quiet);
        add(1'b1, p_tick,  seq_base[k-1], seq_idx[k-1], seq_busy[k-1][0], k == 9);
        add(1'b0, p_quiet, seq_base[k-1], seq_idx[k-1], seq_busy[k-1][0], 1'b0);
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        @(negedge vga_clk);
        frame_tick = 1'b0;
        @(negedge vga_clk);
    endtask

    initial begin
        logic stable;

        // Ticks without requests keep the stance frame.
        add(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        // Single punch; an extra edge during PUNCH is ignored.
        add(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        add_tick(1, 1'b1, 1'b1);
        add_tick(2, 1'b1, 1'b0);
        add_tick(3, 1'b0, 1'b1);
        for (int k = 4; k <= 9; k++) add_tick(k, 1'b1, 1'b1);
        add(1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
        // Held through PUNCH, re-pressed in COOLDOWN: chained restart.
        add(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) add_tick(k, 1'b1, 1'b1);
        add(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 0, 0, 1'b1, 1'b0);
        add_tick(8, 1'b1, 1'b1);
        add(1'b1, 1'b1, 8280, 1, 1'b1, 1'b1);
        add(1'b0, 1'b0, 8280, 1, 1'b1, 1'b0);
        for (int k = 2; k <= 9; k++) add_tick(k, 1'b0, 1'b0);
        // Edge in the same cycle as the tick while IDLE.
        add(1'b1, 1'b1, 8280, 1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 8280, 1, 1'b1, 1'b0);
        for (int k = 2; k <= 9; k++) add_tick(k, 1'b0, 1'b0);

        // Reset state.
        @(negedge vga_clk);
        @(negedge vga_clk);
        chk("reset base", frame_base, 0);
        chk("reset idx",  frame_idx,  0);
        chk("reset busy", busy,       0);
        chk("reset done", anim_done,  0);
        reset_n = 1'b1;
        @(negedge vga_clk);

        foreach (vecs[i]) begin
            frame_tick = vecs[i].tick;
            punch_req  = vecs[i].punch;
            @(negedge vga_clk);
            chk($sformatf("vec%0d base", i), frame_base, vecs[i].base);
            chk($sformatf("vec%0d idx",  i), frame_idx,  vecs[i].idx);
            chk($sformatf("vec%0d busy", i), busy,       vecs[i].busy);
            chk($sformatf("vec%0d done", i), anim_done,  vecs[i].done);
        end
        frame_tick = 1'b0;

        // Request with no tick for 1000 cycles: nothing moves until the tick.
        punch_req = 1'b1;
        stable = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge vga_clk);
            if (frame_idx !== 2'd0 || frame_base !== 16'd0 || busy !== 1'b0 || anim_done !== 1'b0)
                stable = 1'b0;
        end
        chk("no tick hold", stable, 1);
        frame_tick = 1'b1;
        @(negedge vga_clk);
        frame_tick = 1'b0;
        chk("late start idx",  frame_idx,  1);
        chk("late start base", frame_base, 8280);
        chk("late start busy", busy,       1);
        @(negedge vga_clk);
        pulse_tick();
        pulse_tick();
        chk("pre-reset idx",  frame_idx,  2);
        chk("pre-reset base", frame_base, 16560);

        // Asynchronous reset mid-punch, sampled before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("async rst idx",  frame_idx,  0);
        chk("async rst base", frame_base, 0);
        chk("async rst busy", busy,       0);
        punch_req = 1'b0;
        @(negedge vga_clk);
        reset_n = 1'b1;
        @(negedge vga_clk);
        pulse_tick();
        chk("post-reset idx",  frame_idx,  0);
        chk("post-reset base", frame_base, 0);
        chk("post-reset busy", busy,       0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
